// File: rtl/any1_inst_queue.sv
// Fetch-to-decode instruction queue: extracts the 32-bit word addressed by ip from
// a fetch line and buffers {ip, pip, predict_taken, ir, misalign} in a DEPTH-entry FIFO.
module any1_inst_queue #(
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [576:0]    in_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [96:0]     out_o,
  output logic            out_misalign_o,
  output logic [CNTW-1:0] count_o
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [31:0]     NOP_INSN = 32'h3F3F3F3F;
  localparam logic [CNTW-1:0] FULL     = CNTW'(DEPTH);

  // Select the addressed word; a misaligned ip yields a NOP so decode never sees a torn word.
  function automatic logic [31:0] extract_ir(input logic [31:0] ip, input logic [511:0] line);
    logic [8:0] base;
    base = {ip[5:2], 5'd0};
    if (ip[1:0] != 2'b00) extract_ir = NOP_INSN;
    else                  extract_ir = line[base +: 32];
  endfunction

  logic [31:0]     w_ip;
  logic [31:0]     w_pip;
  logic            w_pt;
  logic [511:0]    w_line;
  logic [31:0]     w_ir;
  logic            w_misalign;
  logic [97:0]     w_entry;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_enq;
  logic            w_deq;
  logic [97:0]     w_head;

  logic [97:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;

  assign w_ip       = in_i[576:545];
  assign w_pip      = in_i[544:513];
  assign w_pt       = in_i[512];
  assign w_line     = in_i[511:0];
  assign w_ir       = extract_ir(w_ip, w_line);
  assign w_misalign = (w_ip[1:0] != 2'b00);
  assign w_entry    = {w_ip, w_pip, w_pt, w_ir, w_misalign};

  // Full/empty come from the occupancy count; pointer equality is ambiguous.
  assign w_in_ready  = (r_count != FULL);
  assign w_out_valid = (r_count != '0);
  assign w_enq       = in_valid_i & w_in_ready & ~flush_i;
  assign w_deq       = w_out_valid & out_ready_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_deq) r_rptr <= r_rptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; stale contents are masked by the count.
  always_ff @(posedge clk_i) begin
    if (w_enq && rst_ni) r_mem[r_wptr] <= w_entry;
  end

  assign w_head = r_mem[r_rptr];

  assign in_ready_o     = w_in_ready;
  assign out_valid_o    = w_out_valid;
  assign out_o          = w_out_valid ? w_head[97:1] : {65'd0, NOP_INSN};
  assign out_misalign_o = w_out_valid & w_head[0];
  assign count_o        = r_count;

endmodule
